// File: rtl/register_file_loader.sv
// Write-side sequencer for the latch-based register file: valid/ready stream in, auto-incrementing
// write port out. Optional XOR checksum output enabled by REGISTER_FILE_LOADER_CHECKSUM_EN.
module register_file_loader #(
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned StartAddr = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth:0]   len_i,
    input  logic                 abort_i,
    input  logic                 in_valid_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 in_ready_o,
    output logic [AddrWidth-1:0] waddr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 we_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth:0]   count_o
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
    ,
    output logic [DataWidth-1:0] checksum_o
`endif
);

    localparam logic [AddrWidth:0]   NumWordsL  = {1'b1, {AddrWidth{1'b0}}};
    localparam logic [AddrWidth-1:0] StartAddrL = AddrWidth'(StartAddr);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e               state_q;
    logic [AddrWidth:0]   len_q;
    logic [AddrWidth:0]   count_q;
    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] waddr_q;
    logic [DataWidth-1:0] wdata_q;
    logic                 in_ready_q;
    logic                 we_q;
    logic                 done_q;
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
    logic [DataWidth-1:0] csum_q;
`endif

    logic               handshake;
    logic [AddrWidth:0] len_clamp;
    logic [AddrWidth:0] count_inc;

    assign handshake = in_valid_i & in_ready_q;
    // Over-long requests are clamped so a load never laps the file.
    assign len_clamp = (len_i > NumWordsL) ? NumWordsL : len_i;
    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            len_q      <= '0;
            count_q    <= '0;
            addr_q     <= StartAddrL;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else if (abort_i) begin
            // A word accepted in this cycle is dropped; count_q keeps the words already written.
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    we_q <= 1'b0;
                    if (state_q == StDone) begin
                        done_q <= 1'b1;
                    end
                    if (start_i) begin
                        len_q   <= len_clamp;
                        addr_q  <= StartAddrL;
                        count_q <= '0;
                        done_q  <= 1'b0;
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                        if (len_clamp != '0) begin
                            state_q    <= StLoad;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StLoad: begin
                    we_q <= handshake;
                    if (handshake) begin
                        waddr_q <= addr_q;
                        wdata_q <= in_data_i;
                        addr_q  <= addr_q + 1'b1;
                        count_q <= count_inc;
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ in_data_i;
`endif
                        if (count_inc == len_q) begin
                            in_ready_q <= 1'b0;
                            state_q    <= StDone;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    we_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign we_o       = we_q;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign busy_o     = (state_q == StLoad) | we_q;
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
    assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_register_file_loader.sv
// Randomized bench for register_file_loader: two instances (StartAddr 0 and 14) share stimulus
// and are checked against a transaction-level model of accepted words and expected writes.
module tb_register_file_loader;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, in_valid;
    logic [AW:0]   len;
    logic [DW-1:0] in_data;

    logic          in_ready[2];
    logic          we[2];
    logic          busy[2];
    logic          done[2];
    logic [AW-1:0] waddr[2];
    logic [DW-1:0] wdata[2];
    logic [AW:0]   count[2];
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum[2];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] wa0[$], wa1[$];
    logic [DW-1:0] wd0[$], wd1[$];
    logic [DW-1:0] rf0[NW], rf1[NW];
    logic [DW-1:0] feed[$];

    always #5 clk = ~clk;

    register_file_loader #(.AddrWidth(AW), .DataWidth(DW), .StartAddr(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .abort_i(abort),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready[0]),
        .waddr_o(waddr[0]), .wdata_o(wdata[0]), .we_o(we[0]), .busy_o(busy[0]),
        .done_o(done[0]), .count_o(count[0])
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
        , .checksum_o(csum[0])
`endif
    );

    register_file_loader #(.AddrWidth(AW), .DataWidth(DW), .StartAddr(14)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .abort_i(abort),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready[1]),
        .waddr_o(waddr[1]), .wdata_o(wdata[1]), .we_o(we[1]), .busy_o(busy[1]),
        .done_o(done[1]), .count_o(count[1])
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
        , .checksum_o(csum[1])
`endif
    );

    // Register-file image built from whatever the write port actually drives.
    always @(negedge clk) begin
        if (we[0]) begin
            wa0.push_back(waddr[0]);
            wd0.push_back(wdata[0]);
            rf0[waddr[0]] = wdata[0];
        end
        if (we[1]) begin
            wa1.push_back(waddr[1]);
            wd1.push_back(wdata[1]);
            rf1[waddr[1]] = wdata[1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] next_word();
        if (feed.size() != 0) return feed.pop_front();
        return DW'($urandom);
    endfunction

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_in_ready", tag, d), in_ready[d], 0);
            check($sformatf("%s_d%0d_we", tag, d), we[d], 0);
            check($sformatf("%s_d%0d_waddr", tag, d), waddr[d], 0);
            check($sformatf("%s_d%0d_wdata", tag, d), wdata[d], 0);
            check($sformatf("%s_d%0d_busy", tag, d), busy[d], 0);
            check($sformatf("%s_d%0d_done", tag, d), done[d], 0);
            check($sformatf("%s_d%0d_count", tag, d), count[d], 0);
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
            check($sformatf("%s_d%0d_csum", tag, d), csum[d], 0);
`endif
        end
    endtask

    // vprob < 0 means in_valid toggles 1,0,1,0; abort_at = n aborts on the n-th handshake.
    task automatic run_load(input int len_req, input int vprob, input int abort_at);
        int            eff, acc, cyc;
        logic          exp_we, hs, aborted, tog;
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] x;
        eff = (len_req > NW) ? NW : len_req;
        wa0.delete(); wa1.delete(); wd0.delete(); wd1.delete();
        acc = 0; cyc = 0; exp_we = 1'b0; aborted = 1'b0; tog = 1'b1;
        start = 1'b1;
        len   = len_req[AW:0];
        @(negedge clk);
        start = 1'b0;
        while (acc < eff && !aborted && cyc < 500) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("load_d%0d_we", d), we[d], exp_we);
                check($sformatf("load_d%0d_in_ready", d), in_ready[d], 1);
                check($sformatf("load_d%0d_busy", d), busy[d], 1);
            end
            if (vprob < 0) begin
                in_valid = tog;
                tog      = ~tog;
            end else begin
                in_valid = ($urandom_range(99) < vprob);
            end
            in_data = in_valid ? next_word() : DW'($urandom);
            hs      = in_valid;
            abort   = hs && (acc + 1 == abort_at);
            @(negedge clk);
            cyc++;
            if (hs && !abort) begin
                exp_q.push_back(in_data);
                acc++;
            end
            aborted  = abort;
            exp_we   = hs && !abort;
            in_valid = 1'b0;
            abort    = 1'b0;
        end
        check("load_cycle_bound", cyc < 500, 1);
        x = '0;
        foreach (exp_q[i]) x ^= exp_q[i];
        for (int d = 0; d < 2; d++) begin
            if (aborted) begin
                check($sformatf("abort_d%0d_we", d), we[d], 0);
                check($sformatf("abort_d%0d_done", d), done[d], 0);
                check($sformatf("abort_d%0d_busy", d), busy[d], 0);
                check($sformatf("abort_d%0d_in_ready", d), in_ready[d], 0);
                check($sformatf("abort_d%0d_count", d), count[d], acc);
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
                check($sformatf("abort_d%0d_csum", d), csum[d], 0);
`endif
            end else begin
                check($sformatf("last_d%0d_we", d), we[d], exp_we);
                check($sformatf("last_d%0d_busy", d), busy[d], exp_we);
                check($sformatf("last_d%0d_in_ready", d), in_ready[d], 0);
                check($sformatf("last_d%0d_done", d), done[d], 0);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("end_d%0d_done", d), done[d], !aborted);
            check($sformatf("end_d%0d_busy", d), busy[d], 0);
            check($sformatf("end_d%0d_we", d), we[d], 0);
            check($sformatf("end_d%0d_count", d), count[d], acc);
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
            check($sformatf("end_d%0d_csum", d), csum[d], aborted ? 0 : x);
`endif
        end
        check("d0_nwrites", wa0.size(), exp_q.size());
        check("d1_nwrites", wa1.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wa0.size() && i < wa1.size(); i++) begin
            check($sformatf("d0_waddr[%0d]", i), wa0[i], i % NW);
            check($sformatf("d0_wdata[%0d]", i), wd0[i], exp_q[i]);
            check($sformatf("d1_waddr[%0d]", i), wa1[i], (14 + i) % NW);
            check($sformatf("d1_wdata[%0d]", i), wd1[i], exp_q[i]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; len = '0; in_data = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) feed.push_back(DW'(16'h1000 + i));
        run_load(16, 100, 0);
        check("rf0_addr5", rf0[5], 16'h1005);

        feed.push_back(16'hAAAA); feed.push_back(16'hBBBB);
        feed.push_back(16'hCCCC); feed.push_back(16'hDDDD);
        run_load(4, 100, 0);
        check("rf1_addr14", rf1[14], 16'hAAAA);
        check("rf1_addr15", rf1[15], 16'hBBBB);
        check("rf1_addr0", rf1[0], 16'hCCCC);
        check("rf1_addr1", rf1[1], 16'hDDDD);

        run_load(8, -1, 0);
        run_load(8, 100, 3);
        run_load(0, 100, 0);

        feed.push_back(16'h00FF); feed.push_back(16'h0F0F); feed.push_back(16'hF000);
        run_load(3, 100, 0);
`ifdef REGISTER_FILE_LOADER_CHECKSUM_EN
        check("csum_directed", csum[0], 16'hFFF0);
`endif

        run_load(20, 70, 0);
        for (int k = 0; k < 10; k++) begin
            int l;
            l = $urandom_range(20);
            run_load(l, $urandom_range(30, 100),
                     ($urandom_range(3) == 0 && l > 0) ? $urandom_range(1, (l > NW) ? NW : l) : 0);
        end

        // Reset three words into a load: everything must be back to zero next cycle.
        start = 1'b1; len = 5'd8;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        run_load(5, 100, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
